// File: rtl/p2s_pkg.sv
// Shared definitions for the p2s_stream parallel-to-serial converter:
// counter sizing helper and the registered serial-output bundle.
package p2s_pkg;

    // Bits needed to hold a count of 0..value-1 (at least 1 for value >= 2).
    function automatic int p2s_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int P2S_DEFAULT_WIDTH = 8;
    localparam int P2S_DEFAULT_CNT_W = p2s_clog2(P2S_DEFAULT_WIDTH);

    typedef struct packed {
        logic data;
        logic vld;
        logic sof;
        logic eof;
    } p2s_out_t;

    localparam p2s_out_t P2S_OUT_IDLE = '{data: 1'b0, vld: 1'b0, sof: 1'b0, eof: 1'b0};

endpackage

// File: rtl/p2s_hold.sv
// One-entry valid/ready holding register feeding the serializer.
// Clear wins over accept; accept and pop never coincide since in_ready is low while full.
module p2s_hold
    import p2s_pkg::*;
#(
    parameter int WIDTH = P2S_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             full_q;
    logic             full_d;
    logic             accept_s;

    assign accept_s = in_valid && !full_q && !clr;

    // Next-state for the holding slot: clear, accept, pop, or hold.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (clr) begin
            full_d = 1'b0;
        end else if (accept_s) begin
            data_d = din;
            full_d = 1'b1;
        end else if (pop) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Holding slot registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q <= {WIDTH{1'b0}};
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign in_ready = !full_q;
    assign dout     = data_q;
    assign full     = full_q;

endmodule

// File: rtl/p2s_stream.sv
// Parallel-to-serial converter with a one-word holding slot so consecutive
// words stream out gaplessly; framed by registered vld/sof/eof.
module p2s_stream
    import p2s_pkg::*;
#(
    parameter int WIDTH     = P2S_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             send,
    output logic             data,
    output logic             vld,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int CNT_W = p2s_clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] hold_dout_s;
    logic             hold_full_s;
    logic             pop_s;

    logic [WIDTH-2:0] sreg_q;
    logic [WIDTH-2:0] sreg_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    p2s_out_t         out_q;
    p2s_out_t         out_d;

    p2s_hold #(.WIDTH(WIDTH)) u_hold (
        .clk      (clk),
        .n_rst    (n_rst),
        .clr      (clr),
        .din      (din),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pop      (pop_s),
        .dout     (hold_dout_s),
        .full     (hold_full_s)
    );

    // Shifter / counter next state; priority is clr, then send, then hold still.
    always_comb begin
        out_d  = P2S_OUT_IDLE;
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        pop_s  = 1'b0;
        if (clr) begin
            cnt_d  = CNT_ZERO;
            sreg_d = {(WIDTH-1){1'b0}};
        end else if (send) begin
            if (cnt_q != CNT_ZERO) begin
                if (MSB_FIRST) begin
                    out_d.data = sreg_q[WIDTH-2];
                    sreg_d     = sreg_q << 1;
                end else begin
                    out_d.data = sreg_q[0];
                    sreg_d     = sreg_q >> 1;
                end
                cnt_d     = cnt_q - CNT_ONE;
                out_d.vld = 1'b1;
                out_d.eof = (cnt_q == CNT_ONE);
            end else if (hold_full_s) begin
                if (MSB_FIRST) begin
                    out_d.data = hold_dout_s[WIDTH-1];
                    sreg_d     = hold_dout_s[WIDTH-2:0];
                end else begin
                    out_d.data = hold_dout_s[0];
                    sreg_d     = hold_dout_s[WIDTH-1:1];
                end
                pop_s     = 1'b1;
                cnt_d     = CNT_LAST;
                out_d.vld = 1'b1;
                out_d.sof = 1'b1;
            end else begin
                out_d = P2S_OUT_IDLE;
            end
        end else begin
            // send low freezes the shifter; only the output framing drops.
            out_d = P2S_OUT_IDLE;
        end
    end

    // Shifter, bit counter and serial output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sreg_q <= {(WIDTH-1){1'b0}};
            cnt_q  <= CNT_ZERO;
            out_q  <= P2S_OUT_IDLE;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign data = out_q.data;
    assign vld  = out_q.vld;
    assign sof  = out_q.sof;
    assign eof  = out_q.eof;
    assign busy = (cnt_q != CNT_ZERO) || hold_full_s;

endmodule

// File: tb/tb_p2s_stream.sv
// Directed bench for p2s_stream: one MSB-first and one LSB-first instance
// share stimulus; expectations are hand-computed bit sequences.
module tb_p2s_stream;

    logic       clk;
    logic       n_rst;
    logic       clr;
    logic [7:0] din;
    logic       in_valid;
    logic       send;

    logic m_in_ready, m_data, m_vld, m_sof, m_eof, m_busy;
    logic l_in_ready, l_data, l_vld, l_sof, l_eof, l_busy;

    int n_vec;
    int n_err;

    p2s_stream #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .n_rst(n_rst), .clr(clr), .din(din), .in_valid(in_valid),
        .in_ready(m_in_ready), .send(send), .data(m_data), .vld(m_vld),
        .sof(m_sof), .eof(m_eof), .busy(m_busy)
    );

    p2s_stream #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .n_rst(n_rst), .clr(clr), .din(din), .in_valid(in_valid),
        .in_ready(l_in_ready), .send(send), .data(l_data), .vld(l_vld),
        .sof(l_sof), .eof(l_eof), .busy(l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst    = 1'b0;
        clr      = 1'b0;
        din      = 8'h00;
        in_valid = 1'b0;
        send     = 1'b0;
        repeat (2) tick();
        n_rst = 1'b1;
        tick();
    endtask

    // Offer a word for exactly one edge (edge 0 of a test).
    task automatic accept_word(input logic [7:0] w);
        din      = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    logic [15:0] exp16;
    logic [15:0] got16;
    logic [7:0]  got8;
    logic [7:0]  exp8;
    int          nbits;
    logic [9:0]  send_pat;

    initial begin
        n_vec = 0;
        n_err = 0;
        do_reset();

        // Reset state
        check_vec("rst_vld",   {31'd0, m_vld},      32'd0);
        check_vec("rst_data",  {31'd0, m_data},     32'd0);
        check_vec("rst_ready", {31'd0, m_in_ready}, 32'd1);
        check_vec("rst_busy",  {31'd0, m_busy},     32'd0);

        // MSB-first single word 8'hA5
        send = 1'b1;
        accept_word(8'hA5);
        check_vec("t2_ready_e0", {31'd0, m_in_ready}, 32'd0);
        check_vec("t2_vld_e0",   {31'd0, m_vld},      32'd0);
        check_vec("t2_busy_e0",  {31'd0, m_busy},     32'd1);
        exp8 = 8'hA5;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_vec($sformatf("t2_data_e%0d", i), {31'd0, m_data}, {31'd0, exp8[8-i]});
            check_vec($sformatf("t2_vld_e%0d", i),  {31'd0, m_vld},  32'd1);
            check_vec($sformatf("t2_sof_e%0d", i),  {31'd0, m_sof},  (i == 1) ? 32'd1 : 32'd0);
            check_vec($sformatf("t2_eof_e%0d", i),  {31'd0, m_eof},  (i == 8) ? 32'd1 : 32'd0);
            if (i == 1) check_vec("t2_ready_e1", {31'd0, m_in_ready}, 32'd1);
        end
        tick();
        check_vec("t2_vld_e9",  {31'd0, m_vld},  32'd0);
        check_vec("t2_busy_e9", {31'd0, m_busy}, 32'd0);

        // Back-to-back A5 then 3C, gapless
        do_reset();
        send = 1'b1;
        accept_word(8'hA5);
        din      = 8'h3C;
        in_valid = 1'b1;
        exp16    = 16'hA53C;
        got16    = 16'h0000;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 1) check_vec("t3_ready_e1", {31'd0, m_in_ready}, 32'd1);
            if (i == 2) begin
                check_vec("t3_ready_e2", {31'd0, m_in_ready}, 32'd0);
                in_valid = 1'b0;
            end
            got16 = {got16[14:0], m_data};
            check_vec($sformatf("t3_vld_e%0d", i), {31'd0, m_vld}, 32'd1);
            check_vec($sformatf("t3_sof_e%0d", i), {31'd0, m_sof},
                      (i == 1 || i == 9) ? 32'd1 : 32'd0);
            check_vec($sformatf("t3_eof_e%0d", i), {31'd0, m_eof},
                      (i == 8 || i == 16) ? 32'd1 : 32'd0);
        end
        check_vec("t3_stream", {16'd0, got16}, {16'd0, exp16});
        tick();
        check_vec("t3_vld_e17", {31'd0, m_vld}, 32'd0);

        // Stall with send pattern 1,1,0,0,1,...
        do_reset();
        send = 1'b1;
        accept_word(8'hA5);
        send_pat = 10'b11_1111_0011;   // bit i-1 drives edge i
        got8  = 8'h00;
        nbits = 0;
        for (int i = 1; i <= 10; i++) begin
            send = send_pat[i-1];
            tick();
            if (i == 3 || i == 4) begin
                check_vec($sformatf("t4_vld_e%0d", i),  {31'd0, m_vld},  32'd0);
                check_vec($sformatf("t4_data_e%0d", i), {31'd0, m_data}, 32'd0);
            end
            if (m_vld) begin
                got8  = {got8[6:0], m_data};
                nbits = nbits + 1;
            end
        end
        check_vec("t4_nbits", nbits, 32'd8);
        check_vec("t4_word",  {24'd0, got8}, 32'h0000_00A5);

        // LSB-first instance with 8'h01, MSB-first sees the mirror image
        do_reset();
        send = 1'b1;
        accept_word(8'h01);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_vec($sformatf("t5_l_data_e%0d", i), {31'd0, l_data}, (i == 1) ? 32'd1 : 32'd0);
            check_vec($sformatf("t5_m_data_e%0d", i), {31'd0, m_data}, (i == 8) ? 32'd1 : 32'd0);
            check_vec($sformatf("t5_l_sof_e%0d", i),  {31'd0, l_sof},  (i == 1) ? 32'd1 : 32'd0);
            check_vec($sformatf("t5_l_eof_e%0d", i),  {31'd0, l_eof},  (i == 8) ? 32'd1 : 32'd0);
        end
        check_vec("t5_l_ready", {31'd0, l_in_ready}, 32'd1);

        // clr at edge 3 with hold full and a concurrent in_valid
        do_reset();
        send = 1'b1;
        accept_word(8'hA5);
        tick();
        accept_word(8'h3C);
        check_vec("t6_ready_e2", {31'd0, m_in_ready}, 32'd0);
        clr      = 1'b1;
        din      = 8'h5A;
        in_valid = 1'b1;
        tick();
        check_vec("t6_vld_e3",   {31'd0, m_vld},      32'd0);
        check_vec("t6_busy_e3",  {31'd0, m_busy},     32'd0);
        check_vec("t6_ready_e3", {31'd0, m_in_ready}, 32'd1);
        clr      = 1'b0;
        in_valid = 1'b0;
        for (int i = 4; i <= 6; i++) begin
            tick();
            check_vec($sformatf("t6_vld_e%0d", i),  {31'd0, m_vld},  32'd0);
            check_vec($sformatf("t6_busy_e%0d", i), {31'd0, m_busy}, 32'd0);
        end

        // Async reset mid-word: bits_left=4 with the hold full
        do_reset();
        send = 1'b1;
        accept_word(8'hA5);
        tick();
        accept_word(8'h3C);
        repeat (2) tick();
        check_vec("t1_vld_pre",  {31'd0, m_vld},  32'd1);
        check_vec("t1_busy_pre", {31'd0, m_busy}, 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check_vec("t1_vld_rst",   {31'd0, m_vld},      32'd0);
        check_vec("t1_data_rst",  {31'd0, m_data},     32'd0);
        check_vec("t1_sof_rst",   {31'd0, m_sof},      32'd0);
        check_vec("t1_eof_rst",   {31'd0, m_eof},      32'd0);
        check_vec("t1_busy_rst",  {31'd0, m_busy},     32'd0);
        check_vec("t1_ready_rst", {31'd0, m_in_ready}, 32'd1);
        #2;
        n_rst = 1'b1;
        tick();
        check_vec("t1_vld_post",   {31'd0, m_vld},      32'd0);
        check_vec("t1_busy_post",  {31'd0, m_busy},     32'd0);
        check_vec("t1_ready_post", {31'd0, m_in_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
